// File: rtl/riscv_dmem_ctrl.sv
// Data-memory responder: byte/half/word loads and stores against an internal
// word-organised RAM, with a fixed number of read wait states that stall the pipeline.
module riscv_dmem_ctrl #(
  parameter int DW     = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          memRd_en_i,
  input  logic          memWr_en_i,
  input  logic [2:0]    Func3_i,
  input  logic [DW-1:0] Addr_i,
  input  logic [DW-1:0] WrData_i,
  output logic [DW-1:0] RdData_o,
  output logic          RdValid_o,
  output logic          Stall_o,
  output logic          Err_o
);

  localparam int NB = DW / 8;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_RESP = 2'd2;
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  logic [1:0]        state_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [DW-1:0]     rd_data_q;
  logic              err_q;

  logic [DW-1:0]     mem [0:(1<<ADDR_W)-1];

  logic              in_idle, f3_ld_ok, f3_st_ok, misalign, illegal;
  logic              ld_go, st_go;
  logic [ADDR_W-1:0] widx;
  logic [NB-1:0]     be;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rd_word, rd_shift, rd_ext;

  // Upper address bits deliberately alias onto the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr_i[DW-1:ADDR_W+2];

  always_comb begin
    in_idle  = (state_q == IDLE);
    widx     = Addr_i[ADDR_W+1:2];
    f3_ld_ok = Func3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    f3_st_ok = Func3_i inside {3'b000, 3'b001, 3'b010};
    misalign = ((Func3_i[1:0] == 2'b01) && Addr_i[0]) ||
               ((Func3_i[1:0] == 2'b10) && (Addr_i[1:0] != 2'b00));
    illegal  = (memRd_en_i || memWr_en_i) &&
               ((memRd_en_i && memWr_en_i) ||
                (memRd_en_i && !f3_ld_ok) ||
                (memWr_en_i && !f3_st_ok) ||
                misalign);
    ld_go    = in_idle && memRd_en_i && !illegal;
    st_go    = in_idle && memWr_en_i && !illegal;
  end

  always_comb begin
    be    = '0;
    wdata = WrData_i;
    case (Func3_i[1:0])
      2'b00: begin
        be[Addr_i[1:0]] = 1'b1;
        wdata = {NB{WrData_i[7:0]}};
      end
      2'b01: begin
        be[{Addr_i[1], 1'b0} +: 2] = 2'b11;
        wdata = {(NB/2){WrData_i[15:0]}};
      end
      default: be = '1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (st_go) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_word  = mem[idx_q];
    rd_shift = rd_word >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  rd_ext = {{(DW-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{(DW-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {{(DW-8){1'b0}}, rd_shift[7:0]};
      3'b101:  rd_ext = {{(DW-16){1'b0}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= in_idle && illegal;
      case (state_q)
        IDLE: begin
          if (ld_go) begin
            idx_q   <= widx;
            f3_q    <= Func3_i;
            off_q   <= Addr_i[1:0];
            cnt_q   <= CNT_INIT;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 3'd0) begin
            rd_data_q <= rd_ext;
            state_q   <= RD_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RD_RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Stall_o   = ld_go || (state_q == RD_WAIT);
  assign RdValid_o = (state_q == RD_RESP);
  assign RdData_o  = rd_data_q;
  assign Err_o     = err_q;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl: stores, extended loads, error pulses,
// address aliasing and reset during a pending load.
module tb_riscv_dmem_ctrl;

  localparam int DW     = 32;
  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_rd, mem_wr;
  logic [2:0]    func3;
  logic [DW-1:0] addr, wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, stall, err;

  int checks = 0;
  int errors = 0;

  riscv_dmem_ctrl #(.DW(DW), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .memRd_en_i (mem_rd),
    .memWr_en_i (mem_wr),
    .Func3_i    (func3),
    .Addr_i     (addr),
    .WrData_i   (wr_data),
    .RdData_o   (rd_data),
    .RdValid_o  (rd_valid),
    .Stall_o    (stall),
    .Err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    func3   = 3'b000;
    addr    = '0;
    wr_data = '0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
    mem_wr = 1'b1; func3 = f3; addr = a; wr_data = d;
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    tick();
    drive_idle();
    #1;
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    mem_rd = 1'b1; func3 = f3; addr = a;
    #1;
    chk({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
    tick();
    for (int c = 1; c <= RD_LAT; c++) begin
      chk({tag, "_stall_wait"}, {31'd0, stall}, 32'd1);
      chk({tag, "_valid_wait"}, {31'd0, rd_valid}, 32'd0);
      tick();
    end
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk({tag, "_stall_resp"}, {31'd0, stall}, 32'd0);
    chk({tag, "_data"}, rd_data, exp);
    tick();
    drive_idle();
    #1;
    chk({tag, "_valid_after"}, {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] prev);
    mem_rd = rd; mem_wr = wr; func3 = f3; addr = a; wr_data = d;
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_err_pre"}, {31'd0, err}, 32'd0);
    tick();
    drive_idle();
    #1;
    chk({tag, "_err"}, {31'd0, err}, 32'd1);
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_data_hold"}, rd_data, prev);
    tick();
    chk({tag, "_err_drop"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    tick();
    chk("rst_data", rd_data, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    do_store("sw10", 3'b010, 32'h10, 32'hDEADBEEF);
    do_load("lw10", 3'b010, 32'h10, 32'hDEADBEEF);

    do_store("sw10z", 3'b010, 32'h10, 32'h0);
    do_store("sb13", 3'b000, 32'h13, 32'h12345680);
    do_load("lb13", 3'b000, 32'h13, 32'hFFFFFF80);
    do_load("lbu13", 3'b100, 32'h13, 32'h00000080);
    do_load("lw10b", 3'b010, 32'h10, 32'h80000000);

    do_store("sw20", 3'b010, 32'h20, 32'h11223344);
    do_store("sh22", 3'b001, 32'h22, 32'hABCD8001);
    do_load("lh22", 3'b001, 32'h22, 32'hFFFF8001);
    do_load("lhu22", 3'b101, 32'h22, 32'h00008001);
    do_load("lbu20", 3'b100, 32'h20, 32'h00000044);
    do_load("lbu21", 3'b100, 32'h21, 32'h00000033);

    do_store("sw00", 3'b010, 32'h0, 32'hCAFEF00D);
    do_err("lw_mis", 1'b1, 1'b0, 3'b010, 32'h02, 32'h0, 32'h00000033);
    do_err("sh_mis", 1'b0, 1'b1, 3'b001, 32'h01, 32'hFFFF, 32'h00000033);
    do_err("st_f3", 1'b0, 1'b1, 3'b011, 32'h0, 32'h55555555, 32'h00000033);
    do_err("ld_f3", 1'b1, 1'b0, 3'b110, 32'h0, 32'h0, 32'h00000033);
    do_err("both", 1'b1, 1'b1, 3'b010, 32'h0, 32'h12345678, 32'h00000033);
    do_load("lw00", 3'b010, 32'h0, 32'hCAFEF00D);
    do_load("lh00", 3'b001, 32'h0, 32'hFFFFF00D);

    do_load("alias", 3'b010, 32'h1010, 32'h80000000);

    do_store("sw40", 3'b010, 32'h40, 32'h5A5AA5A5);
    mem_rd = 1'b1; func3 = 3'b010; addr = 32'h40;
    #1;
    chk("abort_stall_c0", {31'd0, stall}, 32'd1);
    tick();
    chk("abort_stall_c1", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_valid", {31'd0, rd_valid}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_data", rd_data, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < RD_LAT + 2; c++) begin
      tick();
      chk("abort_no_valid", {31'd0, rd_valid}, 32'd0);
      chk("abort_no_stall", {31'd0, stall}, 32'd0);
    end
    do_load("lw40_ret", 3'b010, 32'h40, 32'h5A5AA5A5);
    do_load("lw10_ret", 3'b010, 32'h10, 32'h80000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_ctrl.md
# riscv_dmem_ctrl

Data-memory responder for the RISC-V core. It services the load/store requests that the instruction decoder raises on its memory read/write enables. It performs byte, halfword and word accesses with sign or zero extension, and stalls the pipeline for the read wait states. The block sits between the EX/MEM stage and a word-organised on-chip data RAM, which it owns internally.

## Interface
Parameters:
- DW, 32: data/address width (matches `dw).
- ADDR_W, 10: word-address bits. RAM depth is 2^ADDR_W words.
- RD_LAT, 2: read wait-state cycles, legal range 1..4.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset, asynchronous and active-low.
- memRd_en_i  in  1  load request from the decoder path.
- memWr_en_i  in  1  store request from the decoder path.
- Func3_i  in  3  access size/sign (funct3 of the load/store).
- Addr_i  in  DW  byte address (ALU result).
- WrData_i  in  DW  store data (rs2 value, LSB-aligned).
- RdData_o  out  DW  extended load result.
- RdValid_o  out  1  one-cycle pulse; RdData_o is valid.
- Stall_o  out  1  hold the pipeline; request inputs must stay stable while high.
- Err_o  out  1  one-cycle pulse; illegal or misaligned request.

## Operation
- States: IDLE, RD_WAIT, RD_RESP.
- Request inputs are sampled only in IDLE. They are ignored in RD_WAIT and RD_RESP.
- Legal Func3 for store: 000 SB, 001 SH, 010 SW.
- Legal Func3 for load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Any other Func3 with an enable is illegal.
- Misaligned: halfword with Addr_i[0]=1, or word with Addr_i[1:0]≠0.
- Both enables high is illegal.
- Illegal or misaligned request:
  - no RAM access, no state change, Stall_o stays 0;
  - Err_o pulses high the next cycle;
  - RdData_o holds its value and RdValid_o stays 0.
- Word index is Addr_i[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias/wrap.
- Store in IDLE:
  - lane write enables come from size and Addr_i[1:0];
  - data is replicated into the lanes (byte into the selected byte, half into the selected half);
  - only enabled lanes are written, at the end of the same cycle;
  - no stall; the state stays IDLE.
- Load in IDLE:
  - capture the word index, Func3 and Addr_i[1:0];
  - Stall_o=1 combinationally;
  - load the wait counter with RD_LAT-1 and go to RD_WAIT.
- RD_WAIT:
  - Stall_o=1; the counter decrements each cycle;
  - on the cycle it reads 0, the selected byte/half/word is extracted, sign- or zero-extended into RdData_o, and the state moves to RD_RESP.
- RD_RESP: RdValid_o=1, Stall_o=0, then IDLE unconditionally. The pipeline advances on this edge, so the same load is never re-accepted.
- RdData_o holds its last value until the next load completes.
- RAM contents are not cleared by reset and are retained across reset.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - RdData_o=0, RdValid_o=0, Err_o=0;
  - Stall_o=0, unless a load is presented in IDLE, since Stall_o is combinational.
- Load:
  - accepted in cycle 0;
  - RD_WAIT occupies cycles 1..RD_LAT;
  - RdValid_o is high in cycle RD_LAT+1;
  - Stall_o is high for cycles 0..RD_LAT (RD_LAT+1 cycles) and low in cycle RD_LAT+1.
- Store: zero stall cycles. A load in the very next cycle returns the new data (write-before-read).
- Back-to-back loads: the second load is accepted in the cycle after RD_RESP. There are no idle gaps beyond the RD_RESP cycle.
- Err_o: registered, high exactly one cycle after the offending IDLE cycle.
- Asserting rst_n_i low mid-load: the state returns to IDLE immediately (asynchronously); Stall_o, RdValid_o and Err_o drop; no RdValid_o pulse is emitted for the aborted load.
- After reset deassertion, the first rising edge can accept a request.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 (RD_LAT=2) → Stall_o high 3 cycles; RdValid_o in cycle 3 with RdData_o=0xDEADBEEF.
- SB 0x80 @0x13 over 0x00000000, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80000000.
- SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001; LHU → 0x00008001; bytes @0x20/0x21 unchanged.
- LW @0x02, SH @0x01, and an enable with Func3=011 → each gives Err_o pulse next cycle, no stall, RAM and RdData_o unchanged.
- Both enables high with SW @0x0 → Err_o pulse; location 0x0 unchanged.
- rst_n_i low during RD_WAIT → IDLE, no RdValid_o pulse. Then LW of previously stored data → correct value, proving RAM retention.
